// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the hex font table, the scan state enum and the per-digit register entry.
package seg7_pkg;

  // Segment patterns are ordered g..a and are active-low.
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG7_OFF = 7'h7F;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } seg7_digit_t;

  localparam seg7_digit_t DIGIT_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG7_FONT[value];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// A per-digit register file is latched into a shadow at each slot start; only the shadow drives the pins.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 500,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                  clockIn,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  output logic [6:0]            segment7,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DWELL);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                  state_reg, state_next;
  logic        [CNT_W-1:0]      cnt_reg, cnt_next;
  logic        [IDX_W-1:0]      idx_reg, idx_next;
  seg7_digit_t                  shadow_reg, shadow_next;
  seg7_digit_t [NUM_DIGITS-1:0] regfile_reg;
  logic        [NUM_DIGITS-1:0] wr_en;
  logic                         wr_ready_reg;
  logic        [6:0]            font_seg;
  logic        [6:0]            segment7_reg, segment7_next;
  logic                         dp_reg, dp_next;
  logic        [NUM_DIGITS-1:0] digit_sel_reg, digit_sel_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_en
      assign wr_en[gi] = wr_valid && wr_ready_reg && (wr_addr == 3'(gi));
    end
  endgenerate

  // Out-of-range addresses match no wr_en bit, so they are dropped silently.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      wr_ready_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) regfile_reg[i] <= DIGIT_RESET;
    end else begin
      wr_ready_reg <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en[i]) regfile_reg[i] <= '{value: wr_data, dp: wr_dp, blank: wr_blank};
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 1'b1;
    idx_next    = idx_reg;
    shadow_next = shadow_reg;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_END) begin
          state_next  = SHOW;
          shadow_next = regfile_reg[idx_reg];
        end
      end
      default: begin
        if (cnt_reg == DWELL_END) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
      end
    endcase
  end

  hex_to_seg7 u_font (
    .value (shadow_next.value),
    .seg   (font_seg)
  );

  // Output registers are loaded from the next-state view so pins track the FSM without lag.
  always_comb begin
    digit_sel_next = '1;
    segment7_next  = SEG7_OFF;
    dp_next        = 1'b1;
    if (state_next == SHOW) begin
      digit_sel_next[idx_next] = 1'b0;
      if (!shadow_next.blank) begin
        segment7_next = font_seg;
        dp_next       = ~shadow_next.dp;
      end
    end
  end

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      state_reg     <= BLANK;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shadow_reg    <= DIGIT_RESET;
      digit_sel_reg <= '1;
      segment7_reg  <= SEG7_OFF;
      dp_reg        <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shadow_reg    <= shadow_next;
      digit_sel_reg <= digit_sel_next;
      segment7_reg  <= segment7_next;
      dp_reg        <= dp_next;
    end
  end

  assign wr_ready  = wr_ready_reg;
  assign segment7  = segment7_reg;
  assign dp        = dp_reg;
  assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed plus random writes checked every cycle
// against a time-based model (slot = t / DWELL, position = t % DWELL).
module tb_seg7_scan_ctrl;

  localparam int CLK_HZ       = 1000;
  localparam int SCAN_HZ      = 100;
  localparam int BLANK_CYCLES = 2;
  localparam int NUM_DIGITS   = 4;
  localparam int DWELL        = CLK_HZ / SCAN_HZ;

  typedef struct {
    int val;
    bit pdp;
    bit blank;
  } entry_t;

  logic                  clockIn  = 1'b0;
  logic                  reset    = 1'b1;
  logic                  wr_valid = 1'b0;
  logic [2:0]            wr_addr  = '0;
  logic [3:0]            wr_data  = '0;
  logic                  wr_dp    = 1'b0;
  logic                  wr_blank = 1'b0;
  logic                  wr_ready;
  logic [6:0]            segment7;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit_sel;

  int     checks   = 0;
  int     errors   = 0;
  int     t        = 0;
  bit     in_reset = 1'b1;
  entry_t rf    [NUM_DIGITS];
  entry_t shown [NUM_DIGITS];
  logic [6:0] font [16];

  seg7_scan_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS)
  ) dut (
    .clockIn   (clockIn),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .segment7  (segment7),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  always #5 clockIn = ~clockIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic reset_model();
    t = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      rf[i].val      = 0;
      rf[i].pdp      = 1'b0;
      rf[i].blank    = 1'b1;
      shown[i].val   = 0;
      shown[i].pdp   = 1'b0;
      shown[i].blank = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int pos;
    int d;
    logic [NUM_DIGITS-1:0] es;
    logic [6:0] eg;
    logic ed;
    pos = t % DWELL;
    d   = (t / DWELL) % NUM_DIGITS;
    es  = '1;
    eg  = 7'h7F;
    ed  = 1'b1;
    if (!in_reset && pos >= BLANK_CYCLES) begin
      es[d] = 1'b0;
      if (!shown[d].blank) begin
        eg = font[shown[d].val];
        ed = !shown[d].pdp;
      end
    end
    check("digit_sel", 32'(digit_sel), 32'(es));
    check("segment7", 32'(segment7), 32'(eg));
    check("dp", 32'(dp), 32'(ed));
    check("wr_ready", 32'(wr_ready), 32'(!in_reset && t >= 1));
  endtask

  // One clock: advance the model by the rules, then compare all outputs.
  task automatic step();
    bit acc;
    int d;
    @(posedge clockIn);
    #1;
    if (!in_reset) begin
      acc = wr_valid && (t >= 1);
      t++;
      d = (t / DWELL) % NUM_DIGITS;
      if (t % DWELL == BLANK_CYCLES) shown[d] = rf[d];
      if (acc) begin
        $display("write t=%0d addr=%0d data=%0h dp=%0b blank=%0b%s", t, wr_addr, wr_data,
                 wr_dp, wr_blank, (int'(wr_addr) < NUM_DIGITS) ? "" : " (discarded)");
        if (int'(wr_addr) < NUM_DIGITS) begin
          rf[wr_addr].val   = int'(wr_data);
          rf[wr_addr].pdp   = wr_dp;
          rf[wr_addr].blank = wr_blank;
        end
      end
    end
    check_outputs();
  endtask

  task automatic write(input int addr, input int data, input bit pdp, input bit pblank);
    wr_valid = 1'b1;
    wr_addr  = addr[2:0];
    wr_data  = data[3:0];
    wr_dp    = pdp;
    wr_blank = pblank;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_slot(input int digit, input int pos);
    int k;
    k = 0;
    while (k < 200 && !((t % DWELL) == pos && ((t / DWELL) % NUM_DIGITS) == digit)) begin
      step();
      k++;
    end
    check("wait_slot", 32'(k < 200), 32'd1);
  endtask

  initial begin
    font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset_model();

    // Reset state, then release between edges.
    @(posedge clockIn);
    #1;
    check_outputs();
    @(posedge clockIn);
    #3;
    reset    = 1'b0;
    in_reset = 1'b0;
    check_outputs();

    // Idle frame: all digits blank, anodes scan 0..3.
    repeat (40) step();

    // Digit 2 shows A with decimal point.
    write(2, 4'hA, 1'b1, 1'b0);
    repeat (45) step();

    // Write digit 0 mid-SHOW: old pattern holds until next slot.
    wait_slot(0, 4);
    write(0, 5, 1'b0, 1'b0);
    repeat (45) step();

    // Out-of-range address held valid for a full frame.
    wr_valid = 1'b1;
    wr_addr  = 3'd5;
    wr_data  = 4'h7;
    wr_dp    = 1'b1;
    wr_blank = 1'b0;
    repeat (40) step();
    wr_valid = 1'b0;

    // Every font value through digit 1.
    for (int v = 0; v < 16; v++) begin
      write(1, v, v[0], 1'b0);
      repeat (39) step();
    end

    // Write to the digit being latched on the same edge.
    wait_slot(3, BLANK_CYCLES - 1);
    write(3, 4'hE, 1'b0, 1'b0);
    repeat (45) step();

    // Random traffic including out-of-range addresses.
    repeat (300) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      wr_blank = 1'($urandom_range(0, 3) == 0);
      step();
    end
    wr_valid = 1'b0;

    // Asynchronous reset in the middle of digit 3 SHOW.
    wait_slot(3, 5);
    #2;
    reset    = 1'b1;
    in_reset = 1'b1;
    #1;
    check_outputs();
    repeat (2) begin
      @(posedge clockIn);
      #1;
      check_outputs();
    end
    #2;
    reset    = 1'b0;
    in_reset = 1'b0;
    reset_model();
    check_outputs();
    repeat (45) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
